ram_port_arbiter: RTL

- Shares one single-port, byte-write-enable program/data RAM (1-cycle registered read, no output update during write cycles) between NUM_REQ requesters, e.g. core instruction fetch, core data port and the UART/SPI loader.
- Performs round-robin arbitration with an optional per-port lock for atomic multi-cycle sequences.
- Issues at most one RAM access per cycle and returns one response per accepted access, exactly one cycle later.
- Sits between the requesters and the RAM macro, and is the only driver of the RAM port.

---
 rtl/ram_port_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//
// Shares one single-port, byte-write-enable RAM between NUM_REQ requesters
// (instruction fetch, data port, loader). One access is issued per cycle,
// chosen round-robin, with an optional per-port lock that keeps the grant on
// one requester for atomic multi-cycle sequences. Every accepted access,
// read or write, is acknowledged with a one-hot rvalid_o exactly one cycle
// later. Read data is taken straight from the RAM's registered output.
//
// Ports
//   clock      system clock, rising edge
//   reset_n    asynchronous active-low reset, synchronous release
//   req_i      per-port request level
//   lock_i     per-port lock; keeps the grant while req and lock are high
//   wr_i       per-port direction, 1 = write
//   addr_i     flat per-port word address, port n at [n*ADDR_WIDTH +: ADDR_WIDTH]
//   be_i       flat per-port byte enables (writes only)
//   wdata_i    flat per-port write data
//   gnt_o      one-hot combinational grant; accepted where req_i & gnt_o
//   rvalid_o   one-hot registered response strobe
//   rdata_o    read data, broadcast, valid with rvalid_o for reads
//   ram_we     RAM byte write enables
//   ram_addr   RAM word address
//   ram_din    RAM write data
//   ram_dout   RAM registered read data

module ram_port_arbiter #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned NB_COL     = 4,
  parameter int unsigned COL_WIDTH  = 8
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic [NUM_REQ-1:0]                req_i,
  input  logic [NUM_REQ-1:0]                lock_i,
  input  logic [NUM_REQ-1:0]                wr_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]     addr_i,
  input  logic [NUM_REQ*NB_COL-1:0]         be_i,
  input  logic [NUM_REQ*NB_COL*COL_WIDTH-1:0] wdata_i,
  output logic [NUM_REQ-1:0]                gnt_o,
  output logic [NUM_REQ-1:0]                rvalid_o,
  output logic [NB_COL*COL_WIDTH-1:0]       rdata_o,
  output logic [NB_COL-1:0]                 ram_we,
  output logic [ADDR_WIDTH-1:0]             ram_addr,
  output logic [NB_COL*COL_WIDTH-1:0]       ram_din,
  input  logic [NB_COL*COL_WIDTH-1:0]       ram_dout
);

  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned DATA_W = NB_COL * COL_WIDTH;

  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t LAST_IDX = idx_t'(NUM_REQ - 1);

  // Arbitration state
  idx_t last_ptr;   // most recently granted port; scan starts after it
  idx_t lock_idx;   // lock owner
  logic lock_vld;   // lock owner is valid

  // Combinational selection
  idx_t sel_idx;
  logic sel_vld;
  idx_t cand;
  logic grant_vld;

  // Selection: a valid lock owner that still requests keeps the port;
  // otherwise scan last_ptr+1 .. last_ptr with an explicit modulo, since
  // NUM_REQ need not be a power of two.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    cand    = '0;
    if (lock_vld && req_i[lock_idx]) begin
      sel_vld = 1'b1;
      sel_idx = lock_idx;
    end else begin
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
        cand = idx_t'((32'(last_ptr) + i) % NUM_REQ);
        if (!sel_vld && req_i[cand]) begin
          sel_vld = 1'b1;
          sel_idx = cand;
        end
      end
    end
  end

  // Nothing is granted and the RAM is not written while reset is asserted.
  assign grant_vld = sel_vld & reset_n;

  // RAM port drive: idle values are all zero when nobody is granted.
  // A write with no byte enables leaves ram_we at zero and so behaves as a
  // read at the RAM, while still being acknowledged below.
  always_comb begin
    gnt_o    = '0;
    ram_we   = '0;
    ram_addr = '0;
    ram_din  = '0;
    if (grant_vld) begin
      gnt_o[sel_idx] = 1'b1;
      ram_addr       = addr_i[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
      ram_din        = wdata_i[sel_idx*DATA_W +: DATA_W];
      if (wr_i[sel_idx]) begin
        ram_we = be_i[sel_idx*NB_COL +: NB_COL];
      end
    end
  end

  // The RAM output already carries the one-cycle registered latency and
  // holds its value during write cycles, so read data needs no local storage.
  assign rdata_o = ram_dout;

  // Accepting edge bookkeeping. The pending response is held directly as
  // the one-hot rvalid_o register, so an asynchronous reset discards it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_ptr <= LAST_IDX;
      lock_idx <= '0;
      lock_vld <= 1'b0;
      rvalid_o <= '0;
    end else begin
      rvalid_o <= '0;
      if (grant_vld) begin
        last_ptr          <= sel_idx;
        lock_idx          <= sel_idx;
        lock_vld          <= lock_i[sel_idx];
        rvalid_o[sel_idx] <= 1'b1;
      end else begin
        // No grant means no port requests, so a lock owner has dropped req.
        lock_vld <= 1'b0;
      end
    end
  end

endmodule
